// File: rtl/alu_checker.sv
// Scoreboard for the registered 4-bit ALU: delays each presented vector by the ALU
// latency, recomputes the expected {carry,result}, and keeps counts plus a first-fail snapshot.
module alu_checker #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              stop_on_err,
  input  logic              vld,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  dut_result,
  input  logic              dut_carry,
  output logic              mismatch,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  chk_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [2:0]        ff_op,
  output logic [WIDTH-1:0]  ff_a,
  output logic [WIDTH-1:0]  ff_b,
  output logic [WIDTH:0]    ff_exp,
  output logic [WIDTH:0]    ff_got,
  output logic [1:0]        state
);

  localparam int LAST = LATENCY - 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_e;

  state_e              state_q;
  logic                mismatch_q;
  logic                err_sticky_q;
  logic [CNT_W-1:0]    chk_cnt_q, chk_cnt_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [2:0]          ff_op_q;
  logic [WIDTH-1:0]    ff_a_q, ff_b_q;
  logic [WIDTH:0]      ff_exp_q, ff_got_q;

  logic [LATENCY-1:0]  pvld_q;
  logic [WIDTH-1:0]    pa_q  [LATENCY];
  logic [WIDTH-1:0]    pb_q  [LATENCY];
  logic [2:0]          pop_q [LATENCY];

  logic                vld_in;
  logic                chk_fire;
  logic                miss;
  logic [WIDTH:0]      exp_val;
  logic [WIDTH:0]      got_val;

  function automatic logic [WIDTH:0] alu_model(input logic [2:0]       f_op,
                                               input logic [WIDTH-1:0] f_a,
                                               input logic [WIDTH-1:0] f_b);
    logic [WIDTH:0] r;
    r = '0;
    case (f_op)
      3'd0:    r = {1'b0, f_a} + {1'b0, f_b};
      3'd1:    r = {(f_a < f_b), f_a - f_b};
      3'd2:    r = {1'b0, f_a & f_b};
      3'd3:    r = {1'b0, f_a | f_b};
      3'd4:    r = {1'b0, f_a ^ f_b};
      3'd5:    r = {1'b0, ~f_a};
      3'd6:    r = {f_a, 1'b0};
      default: r = {f_a[0], 1'b0, f_a[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Stage boundary: delay line: vectors offered while halted are never queued
  assign vld_in = vld && (state_q != HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pvld_q <= '0;
    end else if (clr) begin
      pvld_q <= '0;
    end else begin
      pvld_q[0] <= vld_in;
      for (int i = 1; i < LATENCY; i++) pvld_q[i] <= pvld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pa_q[0]  <= a;
    pb_q[0]  <= b;
    pop_q[0] <= op;
    for (int i = 1; i < LATENCY; i++) begin
      pa_q[i]  <= pa_q[i-1];
      pb_q[i]  <= pb_q[i-1];
      pop_q[i] <= pop_q[i-1];
    end
  end

  // Stage boundary: compare the oldest vector against what the ALU shows this cycle
  assign exp_val   = alu_model(pop_q[LAST], pa_q[LAST], pb_q[LAST]);
  assign got_val   = {dut_carry, dut_result};
  assign chk_fire  = pvld_q[LAST] && (state_q != HALT);
  assign miss      = chk_fire && (exp_val != got_val);
  assign chk_cnt_d = sat_inc(chk_cnt_q);
  assign err_cnt_d = sat_inc(err_cnt_q);

  // Stage boundary: registered status, counters, capture and FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mismatch_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      chk_cnt_q    <= '0;
      err_cnt_q    <= '0;
      ff_op_q      <= '0;
      ff_a_q       <= '0;
      ff_b_q       <= '0;
      ff_exp_q     <= '0;
      ff_got_q     <= '0;
    end else if (clr) begin
      state_q      <= IDLE;
      mismatch_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      chk_cnt_q    <= '0;
      err_cnt_q    <= '0;
      ff_op_q      <= '0;
      ff_a_q       <= '0;
      ff_b_q       <= '0;
      ff_exp_q     <= '0;
      ff_got_q     <= '0;
    end else begin
      mismatch_q <= miss;
      if (chk_fire) chk_cnt_q <= chk_cnt_d;
      if (miss) begin
        err_cnt_q    <= err_cnt_d;
        err_sticky_q <= 1'b1;
        if (!err_sticky_q) begin
          ff_op_q  <= pop_q[LAST];
          ff_a_q   <= pa_q[LAST];
          ff_b_q   <= pb_q[LAST];
          ff_exp_q <= exp_val;
          ff_got_q <= got_val;
        end
      end
      case (state_q)
        IDLE: begin
          if (miss && stop_on_err) state_q <= HALT;
          else if (vld)            state_q <= RUN;
        end
        RUN: begin
          if (miss && stop_on_err)         state_q <= HALT;
          else if (!vld && pvld_q == '0)   state_q <= IDLE;
        end
        default: state_q <= HALT;
      endcase
    end
  end

  assign mismatch   = mismatch_q;
  assign err_sticky = err_sticky_q;
  assign chk_cnt    = chk_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign ff_op      = ff_op_q;
  assign ff_a       = ff_a_q;
  assign ff_b       = ff_b_q;
  assign ff_exp     = ff_exp_q;
  assign ff_got     = ff_got_q;
  assign state      = state_q;

endmodule

// File: tb/tb_alu_checker.sv
// Directed bench for alu_checker: the bench plays the ALU, emitting hand-computed
// {carry,result} values through a small delay pipe, with faults planted by hand.
module tb_alu_checker;

  logic       clk = 1'b0;
  logic       rst_n, clr, stop_on_err, vld;
  logic [3:0] a, b;
  logic [2:0] op;
  logic [4:0] stim_res;
  logic [4:0] rp [3];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // ALU stand-in: the value given with a vector appears 1 or 3 cycles later
  always @(posedge clk) begin
    rp[0] <= stim_res;
    rp[1] <= rp[0];
    rp[2] <= rp[1];
  end

  logic        o1_mis, o1_stk, o3_mis, o3_stk, o4_mis, o4_stk;
  logic [15:0] o1_chk, o1_err, o3_chk, o3_err;
  logic [3:0]  o4_chk, o4_err;
  logic [2:0]  o1_fop, o3_fop, o4_fop;
  logic [3:0]  o1_fa, o1_fb, o3_fa, o3_fb, o4_fa, o4_fb;
  logic [4:0]  o1_fexp, o1_fgot, o3_fexp, o3_fgot, o4_fexp, o4_fgot;
  logic [1:0]  o1_st, o3_st, o4_st;

  alu_checker #(.WIDTH(4), .LATENCY(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .stop_on_err(stop_on_err), .vld(vld),
    .a(a), .b(b), .op(op), .dut_result(rp[0][3:0]), .dut_carry(rp[0][4]),
    .mismatch(o1_mis), .err_sticky(o1_stk), .chk_cnt(o1_chk), .err_cnt(o1_err),
    .ff_op(o1_fop), .ff_a(o1_fa), .ff_b(o1_fb), .ff_exp(o1_fexp), .ff_got(o1_fgot),
    .state(o1_st));

  alu_checker #(.WIDTH(4), .LATENCY(3), .CNT_W(16)) u3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .stop_on_err(stop_on_err), .vld(vld),
    .a(a), .b(b), .op(op), .dut_result(rp[2][3:0]), .dut_carry(rp[2][4]),
    .mismatch(o3_mis), .err_sticky(o3_stk), .chk_cnt(o3_chk), .err_cnt(o3_err),
    .ff_op(o3_fop), .ff_a(o3_fa), .ff_b(o3_fb), .ff_exp(o3_fexp), .ff_got(o3_fgot),
    .state(o3_st));

  alu_checker #(.WIDTH(4), .LATENCY(1), .CNT_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .stop_on_err(stop_on_err), .vld(vld),
    .a(a), .b(b), .op(op), .dut_result(rp[0][3:0]), .dut_carry(rp[0][4]),
    .mismatch(o4_mis), .err_sticky(o4_stk), .chk_cnt(o4_chk), .err_cnt(o4_err),
    .ff_op(o4_fop), .ff_a(o4_fa), .ff_b(o4_fb), .ff_exp(o4_fexp), .ff_got(o4_fgot),
    .state(o4_st));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] s_op, input logic [3:0] s_a,
                      input logic [3:0] s_b, input logic [4:0] s_res);
    vld = 1'b1; op = s_op; a = s_a; b = s_b; stim_res = s_res;
    step();
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_clr();
    vld = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  logic [4:0] t1_res [8];

  initial begin
    // a=1111, b=0001 for each opcode, {carry,result}
    t1_res[0] = 5'b1_0000; t1_res[1] = 5'b0_1110; t1_res[2] = 5'b0_0001;
    t1_res[3] = 5'b0_1111; t1_res[4] = 5'b0_1110; t1_res[5] = 5'b0_0000;
    t1_res[6] = 5'b1_1110; t1_res[7] = 5'b1_0111;

    rst_n = 1'b0; clr = 1'b0; stop_on_err = 1'b0; vld = 1'b0;
    a = '0; b = '0; op = '0; stim_res = '0;
    step(); step();
    check_eq("rst_state",  32'(o1_st),   32'd0);
    check_eq("rst_chk",    32'(o1_chk),  32'd0);
    check_eq("rst_err",    32'(o1_err),  32'd0);
    check_eq("rst_mis",    32'(o1_mis),  32'd0);
    check_eq("rst_sticky", 32'(o1_stk),  32'd0);
    check_eq("rst_ffexp",  32'(o1_fexp), 32'd0);
    rst_n = 1'b1;
    step();

    // All opcodes, correct ALU, back to back
    do_clr();
    for (int i = 0; i < 8; i++) send(3'(i), 4'hF, 4'h1, t1_res[i]);
    idle(3);
    check_eq("allop_chk",    32'(o1_chk), 32'd8);
    check_eq("allop_err",    32'(o1_err), 32'd0);
    check_eq("allop_sticky", 32'(o1_stk), 32'd0);
    check_eq("allop_idle",   32'(o1_st),  32'd0);

    // Single fault: ADD 1010+1111 = 1_1001, carry dropped
    do_clr();
    send(3'd0, 4'hA, 4'hF, 5'b0_1001);
    check_eq("f1_mis_k1", 32'(o1_mis), 32'd0);
    idle(1);
    check_eq("f1_mis_k2", 32'(o1_mis),  32'd1);
    check_eq("f1_state",  32'(o1_st),   32'd1);
    check_eq("f1_ffexp",  32'(o1_fexp), 32'h19);
    check_eq("f1_ffgot",  32'(o1_fgot), 32'h09);
    check_eq("f1_ffop",   32'(o1_fop),  32'd0);
    check_eq("f1_ffa",    32'(o1_fa),   32'hA);
    check_eq("f1_ffb",    32'(o1_fb),   32'hF);
    step();
    check_eq("f1_mis_k3", 32'(o1_mis), 32'd0);
    check_eq("f1_err",    32'(o1_err), 32'd1);

    // Same fault with halt, then 5 good vectors that must not be checked
    do_clr();
    stop_on_err = 1'b1;
    send(3'd0, 4'hA, 4'hF, 5'b0_1001);
    for (int i = 0; i < 5; i++) send(3'd0, 4'h1, 4'h1, 5'b0_0010);
    idle(4);
    check_eq("h_state",  32'(o1_st),   32'd2);
    check_eq("h_chk",    32'(o1_chk),  32'd1);
    check_eq("h_err",    32'(o1_err),  32'd1);
    check_eq("h_ffexp",  32'(o1_fexp), 32'h19);
    check_eq("h_sticky", 32'(o1_stk),  32'd1);
    stop_on_err = 1'b0;
    idle(2);
    check_eq("h_hold", 32'(o1_st), 32'd2);
    do_clr();
    check_eq("clr_state",  32'(o1_st),   32'd0);
    check_eq("clr_chk",    32'(o1_chk),  32'd0);
    check_eq("clr_err",    32'(o1_err),  32'd0);
    check_eq("clr_ffexp",  32'(o1_fexp), 32'd0);
    check_eq("clr_ffgot",  32'(o1_fgot), 32'd0);
    check_eq("clr_sticky", 32'(o1_stk),  32'd0);

    // Two faults 3 cycles apart; capture keeps the first (SUB 0001-1111 = 1_0010)
    do_clr();
    send(3'd1, 4'h1, 4'hF, 5'b0_0010);
    send(3'd2, 4'h3, 4'h5, 5'b0_0001);
    send(3'd2, 4'h3, 4'h5, 5'b0_0001);
    send(3'd4, 4'h3, 4'h5, 5'b0_0111);
    idle(3);
    check_eq("two_err",   32'(o1_err),  32'd2);
    check_eq("two_chk",   32'(o1_chk),  32'd4);
    check_eq("two_ffop",  32'(o1_fop),  32'd1);
    check_eq("two_ffexp", 32'(o1_fexp), 32'h12);
    check_eq("two_ffgot", 32'(o1_fgot), 32'h02);
    check_eq("two_ffa",   32'(o1_fa),   32'h1);
    check_eq("two_ffb",   32'(o1_fb),   32'hF);

    // Reset with three faulty vectors in flight (LATENCY=3)
    do_clr();
    for (int i = 0; i < 3; i++) send(3'd0, 4'h1, 4'h1, 5'b0_0000);
    vld = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rr_chk",   32'(o3_chk), 32'd0);
    check_eq("rr_err",   32'(o3_err), 32'd0);
    check_eq("rr_mis",   32'(o3_mis), 32'd0);
    check_eq("rr_state", 32'(o3_st),  32'd0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("rr_post_mis", 32'(o3_mis), 32'd0);
    end
    check_eq("rr_post_chk", 32'(o3_chk), 32'd0);
    check_eq("rr_post_err", 32'(o3_err), 32'd0);
    send(3'd0, 4'h1, 4'h1, 5'b0_0010);
    send(3'd0, 4'h1, 4'h1, 5'b0_0000);
    idle(5);
    check_eq("rr_res_chk",   32'(o3_chk),  32'd2);
    check_eq("rr_res_err",   32'(o3_err),  32'd1);
    check_eq("rr_res_ffexp", 32'(o3_fexp), 32'h02);
    check_eq("rr_res_ffgot", 32'(o3_fgot), 32'h00);

    // Counter saturation with CNT_W=4
    do_clr();
    for (int i = 0; i < 20; i++) send(3'd0, 4'h0, 4'h0, 5'b0_0001);
    idle(3);
    check_eq("sat_chk",  32'(o4_chk), 32'hF);
    check_eq("sat_err",  32'(o4_err), 32'hF);
    check_eq("wide_err", 32'(o1_err), 32'd20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_checker.md
# alu_checker

Self-checking monitor for the 4-bit registered ALU. It snoops the operand/opcode vector presented to the ALU and the ALU's `result`/`carry`, and delays each vector to match the ALU's pipeline latency. It computes the expected outputs, compares them, and counts checks and mismatches. It captures the first failing vector for debug and can optionally halt on the first error. It sits beside the ALU in the synthesis wrapper as the consumer end of the ALU's output interface.

## Interface
- `WIDTH`, 4: operand/result width.
- `LATENCY`, 1: ALU cycles from input to result; legal range 1–4.
- `CNT_W`, 16: check/error counter width.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `clr`  in  1  synchronous clear: flush pipeline, zero counters and capture, go to IDLE.
- `stop_on_err`  in  1  when 1, the first mismatch moves the FSM to HALT.
- `vld`  in  1  vector on `a`/`b`/`op` this cycle is to be checked.
- `a`, `b`  in  WIDTH  ALU operands as driven to the ALU.
- `op`  in  3  ALU opcode as driven to the ALU.
- `dut_result`  in  WIDTH  ALU `result`.
- `dut_carry`  in  1  ALU `carry`.
- `mismatch`  out  1  one-cycle pulse per failed check.
- `err_sticky`  out  1  set on any mismatch; cleared only by reset or `clr`.
- `chk_cnt`  out  CNT_W  checks performed; saturates at all-ones.
- `err_cnt`  out  CNT_W  mismatches; saturates at all-ones.
- `ff_op`, `ff_a`, `ff_b`  out  3/WIDTH/WIDTH  first failing vector.
- `ff_exp`, `ff_got`  out  WIDTH+1  `{carry,result}` expected / received at the first fail.
- `state`  out  2  IDLE=00, RUN=01, HALT=10.

## Operation
- Expected model, mod 2^WIDTH:
  - 000 ADD: `{c,r}=a+b`.
  - 001 SUB: `r=a-b`, `c=(a<b)` (borrow).
  - 010 AND: `c=0`.
  - 011 OR: `c=0`.
  - 100 XOR: `c=0`.
  - 101 NOT a: `c=0`.
  - 110 SHL1 a: `c=a[MSB]`, `r[0]=0`.
  - 111 SHR1 a: `c=a[0]`, `r[MSB]=0`.
- Delay line: LATENCY stages, each holding {vld, a, b, op}, and shifting every cycle.
- A check fires when the last stage's vld=1.
- FSM:
  - IDLE → RUN on `vld`=1.
  - RUN → IDLE when `vld`=0 and the delay line is empty.
  - RUN → HALT on a mismatch with `stop_on_err`=1.
  - HALT → IDLE only on `clr`.
- In HALT:
  - The delay line keeps shifting, but no checks fire.
  - Counters, sticky flag and capture hold.
  - `vld` is ignored.
- First-fail capture loads only while `err_sticky`=0. Later mismatches update `err_cnt` but never the capture.
- Counter saturation: at all-ones, a counter stays put and no wrap occurs. `chk_cnt` and `err_cnt` saturate independently.
- `clr` has priority over a same-cycle check: that check is discarded and not counted.
- `stop_on_err` is sampled at the mismatch edge; changing it in HALT has no effect.

## Timing
- Reset values:
  - `state` = IDLE.
  - All counters, `ff_*`, `mismatch`, `err_sticky` = 0.
  - Delay line vld bits = 0.
- Vector presented with `vld`=1 in cycle k is compared against `dut_result`/`dut_carry` sampled at the edge ending cycle k+LATENCY.
- `mismatch`, counters, sticky flag and capture are visible in cycle k+LATENCY+1.
- Back-to-back `vld` gives one check per cycle, with no bubbles.
- `rst_n` low mid-operation: all state clears immediately and in-flight vectors are lost. The ALU shares `rst_n`, so vectors presented during reset are not checked. The bench holds `vld`=0 while `rst_n`=0.
- `clr` takes effect at the next edge. Vectors in the delay line at that edge are dropped.

## Test plan
- LATENCY=1, every op on `a`=1111, `b`=0001, with a correct ALU model:
  - Every result matches: ADD→{1,0000}, SUB→{0,1110}, SHL→{1,1110}, SHR→{1,0111}, etc.
  - `chk_cnt`=8, `err_cnt`=0, `err_sticky`=0.
- ADD `a`=1010, `b`=1111, DUT `carry` forced to 0:
  - `mismatch` pulses exactly in cycle k+2.
  - `ff_exp`=1_1001, `ff_got`=0_1001, `ff_op`=000.
  - `state` stays RUN with `stop_on_err`=0.
- Same fault with `stop_on_err`=1, followed by 5 more valid vectors:
  - `state`=HALT; `chk_cnt`, `err_cnt`=1 and capture are frozen.
  - `clr` returns to IDLE with all zeros.
- Two faults 3 cycles apart (SUB `a`=0001, `b`=1111, then XOR):
  - `err_cnt`=2.
  - Capture still holds the SUB vector, with `ff_exp`=1_0010.
- `rst_n` pulsed low for 2 cycles while 3 vectors are in flight (LATENCY=3):
  - No mismatch or count for those vectors; outputs read 0 during reset.
  - Checking resumes correctly afterwards.
- `CNT_W`=4, 20 faulty vectors:
  - `err_cnt` and `chk_cnt` hold at 1111 with no wrap.
